// File: rtl/bsc_fifo_pkg.sv
// Shared FIFO helpers: width functions, operation decode type, warning macro.
// Latency: n/a (types, functions and a macro only).
// Backpressure: n/a.
//
// Contents:
//   clog2_min1(n)  max(1, $clog2(n)), so a pointer is never zero bits wide
//   ptr_w_of(d)    pointer width for a d-entry FIFO
//   cnt_w_of(d)    occupancy counter width for a d-entry FIFO (holds 0..d)
//   fifo_op_e      per-cycle operation after legality filtering
//   BSC_FIFO_WARN  simulation-only warning that names the calling instance

`ifndef BSC_FIFO_WARN
`define BSC_FIFO_WARN(msg) $display("%0t WARNING %m: %s", $time, msg)
`endif

package bsc_fifo_pkg;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int ptr_w_of(input int depth);
        return clog2_min1(depth);
    endfunction

    // Counter must represent DEPTH itself, hence depth+1 states.
    function automatic int cnt_w_of(input int depth);
        return clog2_min1(depth + 1);
    endfunction

    // Defaults for the common depth-4 configuration.
    localparam int PTR_W = ptr_w_of(4);
    localparam int CNT_W = cnt_w_of(4);

    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_ENQ  = 3'd1,
        OP_DEQ  = 3'd2,
        OP_BOTH = 3'd3,
        OP_CLR  = 3'd4
    } fifo_op_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Mod-DEPTH pointer: increments by one, wraps DEPTH-1 -> 0, clears to 0.
// Latency: pointer updates on the clock edge after inc/clr.
// Backpressure: none; caller decides when inc is legal.
//
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-low reset, pointer -> 0
//   inc  advance pointer by one (ignored while clr=1)
//   clr  synchronous return to 0, wins over inc
//   ptr  current pointer value, always < DEPTH

module fifo_ptr_wrap
    import bsc_fifo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = ptr_w_of(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [PTR_WIDTH-1:0] ptr
);

    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

    logic [PTR_WIDTH-1:0] ptr_nxt;

    // Explicit wrap compare: DEPTH need not be a power of two, so binary
    // overflow of the register would land on an out-of-range slot.
    always_comb begin
        ptr_nxt = ptr;
        if (clr) begin
            ptr_nxt = '0;
        end else if (inc) begin
            ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/fifol_depth_n.sv
// DEPTH-entry loopy FIFO with occupancy count, almost-full flag and flush.
// Latency: enqueue in cycle t visible on D_OUT/EMPTY_N at t+1 when empty.
// Backpressure: FULL_N low when full, but DEQ relieves it combinationally.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   D_IN         enqueue data
//   ENQ          enqueue strobe, legal only while FULL_N=1
//   DEQ          dequeue strobe, legal only while EMPTY_N=1
//   CLR          synchronous flush of pointers and count
//   FULL_N       not full, or DEQ this cycle (combinational from DEQ)
//   EMPTY_N      at least one entry held (registered)
//   D_OUT        head entry, valid while EMPTY_N=1
//   COUNT        occupancy (registered)
//   ALMOST_FULL  COUNT >= AFULL_LVL (registered)

module fifol_depth_n
    import bsc_fifo_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int DEPTH         = 4,
    parameter int AFULL_LVL     = DEPTH - 1,
    parameter bit RESET_STORAGE = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           D_IN,
    input  logic                       ENQ,
    input  logic                       DEQ,
    input  logic                       CLR,
    output logic                       FULL_N,
    output logic                       EMPTY_N,
    output logic [WIDTH-1:0]           D_OUT,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       ALMOST_FULL
);

    localparam int PTR_WIDTH = ptr_w_of(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AFULL = CNT_WIDTH'(AFULL_LVL);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 afull_q;

    logic     full;
    logic     enq_eff;
    logic     deq_eff;
    logic     wr_inc;
    logic     rd_inc;
    logic     ptr_clr;
    fifo_op_e op;

    // ---------------------------------------------------------------
    // Status and legality filtering
    // ---------------------------------------------------------------
    assign full    = (count_q == CNT_FULL);
    assign EMPTY_N = (count_q != '0);
    // A dequeue frees the head slot this cycle, so a full FIFO still
    // accepts a word: it is written into the slot being vacated.
    assign FULL_N  = !full || DEQ;

    assign enq_eff = ENQ && FULL_N;
    assign deq_eff = DEQ && EMPTY_N;

    always_comb begin
        op = OP_IDLE;
        if (CLR) begin
            op = OP_CLR;
        end else if (enq_eff && deq_eff) begin
            op = OP_BOTH;
        end else if (enq_eff) begin
            op = OP_ENQ;
        end else if (deq_eff) begin
            op = OP_DEQ;
        end
    end

    assign wr_inc  = (op == OP_ENQ) || (op == OP_BOTH);
    assign rd_inc  = (op == OP_DEQ) || (op == OP_BOTH);
    assign ptr_clr = (op == OP_CLR);

    // ---------------------------------------------------------------
    // Occupancy and almost-full
    // ---------------------------------------------------------------
    always_comb begin
        count_nxt = count_q;
        case (op)
            OP_CLR:  count_nxt = '0;
            OP_ENQ:  count_nxt = count_q + 1'b1;
            OP_DEQ:  count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Flag derived from the next count so it changes on the same edge
    // as COUNT rather than one cycle behind it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            afull_q <= (count_nxt >= CNT_AFULL);
        end
    end

    assign COUNT       = count_q;
    assign ALMOST_FULL = afull_q;

    // ---------------------------------------------------------------
    // Pointers
    // ---------------------------------------------------------------
    fifo_ptr_wrap #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_wr_ptr (
        .CLK (CLK),
        .RST (RST),
        .inc (wr_inc),
        .clr (ptr_clr),
        .ptr (wr_ptr)
    );

    fifo_ptr_wrap #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .CLK (CLK),
        .RST (RST),
        .inc (rd_inc),
        .clr (ptr_clr),
        .ptr (rd_ptr)
    );

    // ---------------------------------------------------------------
    // Storage; flush leaves contents untouched
    // ---------------------------------------------------------------
    if (RESET_STORAGE) begin : g_mem_rst
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else if (wr_inc) begin
                mem[wr_ptr] <= D_IN;
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge CLK) begin
            if (wr_inc) begin
                mem[wr_ptr] <= D_IN;
            end
        end
    end

    assign D_OUT = mem[rd_ptr];

    // ---------------------------------------------------------------
    // Simulation-only warnings and invariants
    // ---------------------------------------------------------------
`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RST && !CLR) begin
            if (ENQ && !FULL_N) begin
                `BSC_FIFO_WARN("ENQ while full, data dropped");
            end
            if (DEQ && !EMPTY_N) begin
                `BSC_FIFO_WARN("DEQ while empty, ignored");
            end
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            assert (count_q <= CNT_FULL)
                else $error("%m: count %0d exceeds depth %0d", count_q, DEPTH);
            assert ((count_q == '0) == !EMPTY_N)
                else $error("%m: EMPTY_N inconsistent with count");
            assert (int'(rd_ptr) < DEPTH)
                else $error("%m: rd_ptr %0d out of range", rd_ptr);
            assert (int'(wr_ptr) < DEPTH)
                else $error("%m: wr_ptr %0d out of range", wr_ptr);
        end
    end
`endif

endmodule

// File: tb/tb_fifol_depth_n.sv
// Bench for fifol_depth_n: depth-4 (storage reset) and depth-3 instances.
// Latency: scoreboard expects enqueued data on D_OUT one cycle later.
// Backpressure: model predicts FULL_N from occupancy and DEQ.

module tb_fifol_depth_n;

    logic CLK;
    logic RST;

    // depth-4, WIDTH 8, storage zeroed on reset
    logic [7:0] x4;
    logic       e4, d4, c4;
    logic       full_n4, empty_n4, afull4;
    logic [7:0] dout4;
    logic [2:0] count4;

    // depth-3, WIDTH 8, non-power-of-two wrap
    logic [7:0] x3;
    logic       e3, d3, c3;
    logic       full_n3, empty_n3, afull3;
    logic [7:0] dout3;
    logic [1:0] count3;

    int n_chk;
    int n_err;

    logic [7:0] q4[$];
    logic [7:0] q3[$];

    fifol_depth_n #(
        .WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .RESET_STORAGE(1'b1)
    ) u_d4 (
        .CLK(CLK), .RST(RST), .D_IN(x4), .ENQ(e4), .DEQ(d4), .CLR(c4),
        .FULL_N(full_n4), .EMPTY_N(empty_n4), .D_OUT(dout4),
        .COUNT(count4), .ALMOST_FULL(afull4)
    );

    fifol_depth_n #(
        .WIDTH(8), .DEPTH(3), .AFULL_LVL(2), .RESET_STORAGE(1'b0)
    ) u_d3 (
        .CLK(CLK), .RST(RST), .D_IN(x3), .ENQ(e3), .DEQ(d3), .CLR(c3),
        .FULL_N(full_n3), .EMPTY_N(empty_n3), .D_OUT(dout3),
        .COUNT(count3), .ALMOST_FULL(afull3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle on one instance: check registered state against the
    // model, drive strobes, check FULL_N, update model, take the edge.
    task automatic step(input bit sel3, input bit enq, input bit deq,
                        input bit clr, input logic [7:0] din);
        int         sz;
        bit         fn;
        logic [7:0] exp;
        @(negedge CLK);
        if (!sel3) begin
            sz = q4.size();
            check("count4", int'(count4), sz);
            check("empty_n4", int'(empty_n4), int'(sz != 0));
            check("afull4", int'(afull4), int'(sz >= 3));
            if (sz != 0) check("dout4", int'(dout4), int'(q4[0]));
            e4 = enq; d4 = deq; c4 = clr; x4 = din;
            #1;
            fn = (sz < 4) || deq;
            check("full_n4", int'(full_n4), int'(fn));
            if (clr) begin
                q4.delete();
            end else begin
                if (deq && sz != 0) begin
                    exp = q4.pop_front();
                    check("sb4", int'(dout4), int'(exp));
                end
                if (enq && fn) q4.push_back(din);
            end
        end else begin
            sz = q3.size();
            check("count3", int'(count3), sz);
            check("empty_n3", int'(empty_n3), int'(sz != 0));
            check("afull3", int'(afull3), int'(sz >= 2));
            check("rd_ptr3_rng", int'(u_d3.rd_ptr < 2'd3), 1);
            check("wr_ptr3_rng", int'(u_d3.wr_ptr < 2'd3), 1);
            if (sz != 0) check("dout3", int'(dout3), int'(q3[0]));
            e3 = enq; d3 = deq; c3 = clr; x3 = din;
            #1;
            fn = (sz < 3) || deq;
            check("full_n3", int'(full_n3), int'(fn));
            if (clr) begin
                q3.delete();
            end else begin
                if (deq && sz != 0) begin
                    exp = q3.pop_front();
                    check("sb3", int'(dout3), int'(exp));
                end
                if (enq && fn) q3.push_back(din);
            end
        end
        @(posedge CLK);
        #1;
        e4 = 1'b0; d4 = 1'b0; c4 = 1'b0;
        e3 = 1'b0; d3 = 1'b0; c3 = 1'b0;
    endtask

    initial begin
        logic [7:0] fill [4];
        int         guard;
        n_chk = 0;
        n_err = 0;
        RST = 1'b0;
        e4 = 1'b0; d4 = 1'b0; c4 = 1'b0; x4 = 8'h00;
        e3 = 1'b0; d3 = 1'b0; c3 = 1'b0; x3 = 8'h00;

        // Reset state
        #3;
        check("rst_count4", int'(count4), 0);
        check("rst_empty_n4", int'(empty_n4), 0);
        check("rst_afull4", int'(afull4), 0);
        check("rst_full_n4", int'(full_n4), 1);
        check("rst_dout4", int'(dout4), 0);
        check("rst_count3", int'(count3), 0);
        #4 RST = 1'b1;

        // Fill to full, then idle with DEQ=0
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, fill[i]);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Full pass-through
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);

        // Enqueue while full is dropped
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);

        // Drain, then dequeue on empty
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Flush wins over simultaneous enqueue
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0A);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0B);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reach COUNT=3, then async reset between edges
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC7);
        check("pre_arst_count4", int'(count4), 3);
        #2 RST = 1'b0;
        #1;
        check("arst_empty_n4", int'(empty_n4), 0);
        check("arst_count4", int'(count4), 0);
        check("arst_afull4", int'(afull4), 0);
        check("arst_full_n4", int'(full_n4), 1);
        check("arst_dout4", int'(dout4), 0);
        q4.delete();
        q3.delete();
        #2 RST = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Non-power-of-two wrap with interleaved traffic
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i % 3) != 2, (i % 2) == 1, 1'b0, 8'(8'h30 + i));
        end
        guard = 0;
        while (q3.size() != 0 && guard < 8) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            guard++;
        end
        check("drain3_done", q3.size(), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
